// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC, imem req/ready fetch, decode valid/accept, jump/branch redirect, halt.
// Optional FETCH_STATS_EN adds fetch_count / redirect_count outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  output logic [31:0] pc_out,
`ifdef FETCH_STATS_EN
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count,
`endif
  output logic        halted
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc4;
  logic        fetch_hit;
  logic        redirect;

  assign pc4       = pc_q + 32'd4;
  assign fetch_hit = (state_q == FETCH) && imem_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    redirect = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          state_d  = (imem_rdata[31:26] == HALT_OPCODE) ? HALT : HOLD;
        end
      end
      HOLD: begin
        // Control inputs belong to the held instruction and are only meaningful on accept.
        if (instr_accept) begin
          state_d = FETCH;
          if (jump) begin
            pc_d     = {pc4[31:28], jump_target, 2'b00};
            redirect = 1'b1;
          end else if (branch && zero) begin
            pc_d     = pc4 + (branch_offset << 2);
            redirect = 1'b1;
          end else begin
            pc_d = pc4;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      pc_out_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, redirect_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q    <= 32'd0;
      redirect_count_q <= 32'd0;
    end else begin
      if (fetch_hit) fetch_count_q <= fetch_count_q + 32'd1;
      if (redirect)  redirect_count_q <= redirect_count_q + 32'd1;
    end
  end

  assign fetch_count    = fetch_count_q;
  assign redirect_count = redirect_count_q;
`else
  logic unused_stats;
  assign unused_stats = fetch_hit ^ redirect;
`endif

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign halted      = (state_q == HALT);
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-side memory plus a next-PC model computed from the fetch rules.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_accept;
  logic        jump;
  logic [25:0] jump_target;
  logic        branch;
  logic        zero;
  logic [31:0] branch_offset;
  logic [31:0] pc_out;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, redirect_count;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pc;
  int unsigned exp_fetch, exp_redir;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .instr_accept(instr_accept),
    .jump(jump), .jump_target(jump_target), .branch(branch), .zero(zero),
    .branch_offset(branch_offset), .pc_out(pc_out),
`ifdef FETCH_STATS_EN
    .fetch_count(fetch_count), .redirect_count(redirect_count),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next PC from the architectural rules: jump region-relative, branch word offset, else sequential.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic j, input logic [25:0] tgt,
                                           input logic b, input logic z, input logic [31:0] off);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
    if (b && z) return seq + off * 32'd4;
    return seq;
  endfunction

  task automatic do_reset();
    rst = 1'b1; imem_ready = 0; imem_rdata = 0; instr_accept = 0;
    jump = 0; jump_target = 0; branch = 0; zero = 0; branch_offset = 0;
    step(); step();
    rst = 1'b0;
    model_pc = 32'd0; exp_fetch = 0; exp_redir = 0;
  endtask

  // One instruction: wait for request, delay ready, latch, delay accept, redirect.
  task automatic xact(input logic [31:0] word, input int rdly, input int adly, input logic j,
                      input logic [25:0] tgt, input logic b, input logic z, input logic [31:0] off);
    int waited = 0;
    while (imem_req !== 1'b1 && waited < 50) begin step(); waited++; end
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_fail++; $display("FAIL req_timeout: imem_req=%b required 1", imem_req); return;
    end
    n_checks++;
    if (imem_addr !== model_pc) begin
      n_fail++; $display("FAIL fetch_addr: got %h required %h", imem_addr, model_pc);
    end
    for (int i = 0; i < rdly; i++) begin
      imem_ready = 0; imem_rdata = $urandom; step();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL wait_stable: req=%b addr=%h valid=%b required 1/%h/0",
                           imem_req, imem_addr, instr_valid, model_pc);
      end
    end
    imem_ready = 1; imem_rdata = word; step();
    imem_ready = 0; imem_rdata = $urandom; exp_fetch++;
    n_checks++;
    if (instr !== word || opcode !== word[31:26] || pc_out !== model_pc) begin
      n_fail++; $display("FAIL latch: instr=%h op=%h pc_out=%h required %h/%h/%h",
                         instr, opcode, pc_out, word, word[31:26], model_pc);
    end
    if (word[31:26] == 6'h3F) begin
      n_checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL halt_enter: halted=%b valid=%b req=%b required 1/0/0",
                           halted, instr_valid, imem_req);
      end
      return;
    end
    n_checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL hold_enter: valid=%b req=%b halted=%b required 1/0/0",
                         instr_valid, imem_req, halted);
    end
    for (int i = 0; i < adly; i++) begin
      instr_accept = 0; jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom);
      jump_target = 26'($urandom); branch_offset = $urandom; imem_ready = 1'($urandom);
      step();
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== word || imem_addr !== model_pc) begin
        n_fail++; $display("FAIL hold_stable: valid=%b instr=%h addr=%h required 1/%h/%h",
                           instr_valid, instr, imem_addr, word, model_pc);
      end
    end
    imem_ready = 0;
    instr_accept = 1; jump = j; jump_target = tgt; branch = b; zero = z; branch_offset = off;
    step();
    instr_accept = 0; jump = 0; branch = 0; zero = 0; jump_target = 0; branch_offset = 0;
    if (j || (b && z)) exp_redir++;
    model_pc = ref_next(model_pc, j, tgt, b, z, off);
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== model_pc) begin
      n_fail++; $display("FAIL next_pc: valid=%b req=%b addr=%h required 0/1/%h",
                         instr_valid, imem_req, imem_addr, model_pc);
    end
`ifdef FETCH_STATS_EN
    n_checks++;
    if (fetch_count !== 32'(exp_fetch) || redirect_count !== 32'(exp_redir)) begin
      n_fail++; $display("FAIL stats: fetch=%0d redir=%0d required %0d/%0d",
                         fetch_count, redirect_count, exp_fetch, exp_redir);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 0; imem_rdata = 0; instr_accept = 0;
    jump = 0; jump_target = 0; branch = 0; zero = 0; branch_offset = 0;
    step(); step();
    n_checks++;
    if (imem_req !== 0 || instr_valid !== 0 || halted !== 0 || instr !== 0 || pc_out !== 0 ||
        imem_addr !== 32'd0) begin
      n_fail++; $display("FAIL reset_vals: req=%b valid=%b halted=%b instr=%h pc_out=%h addr=%h required all 0",
                         imem_req, instr_valid, halted, instr, pc_out, imem_addr);
    end
    rst = 1'b0; #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL boot_idle: imem_req=%b required 0", imem_req);
    end
    step();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_fail++; $display("FAIL boot_to_fetch: req=%b addr=%h required 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_jump();
    do_reset();
    xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    xact(32'h0800_0040, 0, 0, 1, 26'h0000040, 0, 0, 0);
    n_checks++;
    if (model_pc !== 32'h0000_0100 || imem_addr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL jump_target: addr=%h required 00000100", imem_addr);
    end
    xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 4; i++) xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    xact(32'h1000_FFFE, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFE);
    n_checks++;
    if (imem_addr !== 32'd12) begin
      n_fail++; $display("FAIL branch_taken: addr=%h required 0000000c", imem_addr);
    end
    xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    xact(32'h1000_FFFE, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFE);
    n_checks++;
    if (imem_addr !== 32'd20) begin
      n_fail++; $display("FAIL branch_not_taken: addr=%h required 00000014", imem_addr);
    end
    xact(32'h0800_0040, 0, 0, 1, 26'h0000080, 1, 1, 32'hFFFF_FFFE);
    n_checks++;
    if (imem_addr !== 32'h0000_0200) begin
      n_fail++; $display("FAIL jump_priority: addr=%h required 00000200", imem_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    xact(32'h0123_4567, 5, 3, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    xact(32'h1000_FFFE, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFE);
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL neg_wrap: addr=%h required fffffffc", imem_addr);
    end
    xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (imem_addr !== 32'd0) begin
      n_fail++; $display("FAIL pc4_wrap: addr=%h required 00000000", imem_addr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    xact(32'hFC00_0000, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) begin
      imem_ready = 1'($urandom); instr_accept = 1'($urandom); imem_rdata = $urandom;
      step();
      n_checks++;
      if (imem_req !== 0 || instr_valid !== 0 || halted !== 1) begin
        n_fail++; $display("FAIL halt_sticky: req=%b valid=%b halted=%b required 0/0/1",
                           imem_req, instr_valid, halted);
      end
    end
    do_reset();
    n_checks++;
    if (imem_addr !== 32'd0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_reset: addr=%h halted=%b required 0/0", imem_addr, halted);
    end
    xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); step();
    rst = 1'b1; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    step(); step();
    n_checks++;
    if (instr !== 0 || instr_valid !== 0 || imem_req !== 0) begin
      n_fail++; $display("FAIL reset_mid: instr=%h valid=%b req=%b required 0/0/0",
                         instr, instr_valid, imem_req);
    end
    rst = 1'b0; model_pc = 0; exp_fetch = 0; exp_redir = 0;
    step();
    imem_ready = 0;
    n_checks++;
    if (instr !== 0 || instr_valid !== 0) begin
      n_fail++; $display("FAIL late_ready: instr=%h valid=%b required 0/0", instr, instr_valid);
    end
    xact(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] w;
    int o;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      if (w[31:26] == 6'h3F) w[31] = 1'b0;
      o = int'($urandom_range(0, 16)) - 8;
      xact(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
           26'($urandom), 1'($urandom), 1'($urandom), 32'(o));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_stall();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
